// File: rtl/sync_fifo_pkg.sv
// Shared defaults and pointer/count typedefs for the single-clock FIFO.
// The typedefs are sized for the default ADDRSIZE.
package sync_fifo_pkg;
    localparam int unsigned DEF_DATASIZE = 8;
    localparam int unsigned DEF_ADDRSIZE = 9;

    typedef logic [DEF_ADDRSIZE:0] ptr_t;
    typedef logic [DEF_ADDRSIZE:0] count_t;

    function automatic int unsigned fifo_depth(input int unsigned asz);
        return 32'd1 << asz;
    endfunction
endpackage

// File: rtl/sync_fifo_mem.sv
// 2^ADDRSIZE x DATASIZE storage with one write and one read port.
// SYNC_FIFO_FWFT_EN selects a combinational read port; the default is registered.
module sync_fifo_mem #(
    parameter int unsigned DATASIZE = 8,
    parameter int unsigned ADDRSIZE = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDRSIZE-1:0] waddr,
    input  logic [DATASIZE-1:0] wdata,
    input  logic                re,
    input  logic [ADDRSIZE-1:0] raddr,
    output logic [DATASIZE-1:0] rdata
);
    logic [DATASIZE-1:0] mem [2**ADDRSIZE];

    // Array is deliberately not reset; only the pointers define valid contents.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = mem[raddr];

    logic unused_rd_ctl;
    assign unused_rd_ctl = rst ^ re;
`else
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
`endif
endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with thresholds, occupancy count and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned DATASIZE  = DEF_DATASIZE,
    parameter int unsigned ADDRSIZE  = DEF_ADDRSIZE,
    parameter int unsigned AFULL_TH  = fifo_depth(ADDRSIZE) - 4,
    parameter int unsigned AEMPTY_TH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                winc,
    input  logic [DATASIZE-1:0] wdata,
    output logic                wfull,
    output logic                walmost_full,
    input  logic                rinc,
    output logic [DATASIZE-1:0] rdata,
    output logic                rempty,
    output logic                ralmost_empty,
    output logic [ADDRSIZE:0]   count,
    output logic                overflow,
    output logic                underflow
);
    if (!(AEMPTY_TH < AFULL_TH && AFULL_TH <= fifo_depth(ADDRSIZE))) begin : g_bad_th
        $error("sync_fifo_param: need AEMPTY_TH < AFULL_TH <= 2**ADDRSIZE");
    end

    localparam logic [ADDRSIZE:0] ONE_C    = {{ADDRSIZE{1'b0}}, 1'b1};
    localparam logic [ADDRSIZE:0] DEPTH_C  = {1'b1, {ADDRSIZE{1'b0}}};
    localparam logic [ADDRSIZE:0] AFULL_C  = AFULL_TH[ADDRSIZE:0];
    localparam logic [ADDRSIZE:0] AEMPTY_C = AEMPTY_TH[ADDRSIZE:0];

    logic [ADDRSIZE:0] wptr, rptr;
    logic              wen, ren;

    // Acceptance uses only registered flags, so no winc/rinc -> flag path exists.
    assign wen = winc && !wfull;
    assign ren = rinc && !rempty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wen) wptr <= wptr + ONE_C;
            if (ren) rptr <= rptr + ONE_C;
            if (wen && !ren)      count <= count + ONE_C;
            else if (ren && !wen) count <= count - ONE_C;
            if (winc && wfull)  overflow  <= 1'b1;
            if (rinc && rempty) underflow <= 1'b1;
        end
    end

    assign wfull         = (count == DEPTH_C);
    assign rempty        = (count == '0);
    assign walmost_full  = (count >= AFULL_C);
    assign ralmost_empty = (count <= AEMPTY_C);

    sync_fifo_mem #(
        .DATASIZE (DATASIZE),
        .ADDRSIZE (ADDRSIZE)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (wen),
        .waddr (wptr[ADDRSIZE-1:0]),
        .wdata (wdata),
        .re    (ren),
        .raddr (rptr[ADDRSIZE-1:0]),
        .rdata (rdata)
    );
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param in registered-read mode: depth 4,
// AFULL_TH=3, AEMPTY_TH=1.
module tb_sync_fifo_param;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       winc = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic       rinc = 1'b0;
    logic       wfull, walmost_full, rempty, ralmost_empty, overflow, underflow;
    logic [7:0] rdata;
    logic [2:0] count;

    int tests = 0;
    int fails = 0;

    sync_fifo_param #(
        .DATASIZE  (8),
        .ADDRSIZE  (2),
        .AFULL_TH  (3),
        .AEMPTY_TH (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .winc          (winc),
        .wdata         (wdata),
        .wfull         (wfull),
        .walmost_full  (walmost_full),
        .rinc          (rinc),
        .rdata         (rdata),
        .rempty        (rempty),
        .ralmost_empty (ralmost_empty),
        .count         (count),
        .overflow      (overflow),
        .underflow     (underflow)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] flags;
        logic [7:0] exp_flags;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        flags     = {2'b00, rempty, ralmost_empty, wfull, walmost_full, overflow, underflow};
        exp_flags = 8'b0011_0000;
        tests++;
        if (flags !== exp_flags) begin
            fails++;
            $display("FAIL reset_flags: got %b expected %b", flags, exp_flags);
        end
        tests++;
        if (count !== 3'd0) begin
            fails++;
            $display("FAIL reset_count: got %0d expected 0", count);
        end
        tests++;
        if (rdata !== 8'h00) begin
            fails++;
            $display("FAIL reset_rdata: got %h expected 00", rdata);
        end
    endtask

    task automatic test_fill_drain();
        logic [7:0] wv [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [2:0] ec [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [3:0] eaf    = 4'b1100;  // walmost_full expected after writes 1..4 (bit i)
        logic [3:0] ef     = 4'b1000;
        logic [3:0] eae    = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            winc  = 1'b1;
            wdata = wv[i];
            tick();
            tests++;
            if (count !== ec[i] || walmost_full !== eaf[i] || wfull !== ef[i] ||
                ralmost_empty !== eae[i] || rempty !== 1'b0) begin
                fails++;
                $display("FAIL fill_%0d: got cnt=%0d af=%b f=%b ae=%b e=%b expected cnt=%0d af=%b f=%b ae=%b e=0",
                         i, count, walmost_full, wfull, ralmost_empty, rempty,
                         ec[i], eaf[i], ef[i], eae[i]);
            end
        end
        winc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rinc = 1'b1;
            tick();
            tests++;
            if (rdata !== wv[i]) begin
                fails++;
                $display("FAIL drain_%0d: got %h expected %h", i, rdata, wv[i]);
            end
        end
        rinc = 1'b0;
        tick();
        tests++;
        if (count !== 3'd0 || rempty !== 1'b1 || rdata !== 8'h44) begin
            fails++;
            $display("FAIL drain_end: got cnt=%0d e=%b rd=%h expected cnt=0 e=1 rd=44",
                     count, rempty, rdata);
        end
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 4; i++) begin
            winc  = 1'b1;
            wdata = 8'(i);
            tick();
        end
        wdata = 8'h55;
        tick();
        winc = 1'b0;
        tests++;
        if (overflow !== 1'b1 || count !== 3'd4 || wfull !== 1'b1) begin
            fails++;
            $display("FAIL overflow_set: got ovf=%b cnt=%0d f=%b expected ovf=1 cnt=4 f=1",
                     overflow, count, wfull);
        end
        for (int i = 1; i <= 4; i++) begin
            rinc = 1'b1;
            tick();
            tests++;
            if (rdata !== 8'(i)) begin
                fails++;
                $display("FAIL overflow_read_%0d: got %h expected %h", i, rdata, 8'(i));
            end
        end
        rinc = 1'b0;
        tick();
        tests++;
        if (overflow !== 1'b1 || underflow !== 1'b0 || count !== 3'd0) begin
            fails++;
            $display("FAIL overflow_sticky: got ovf=%b udf=%b cnt=%0d expected ovf=1 udf=0 cnt=0",
                     overflow, underflow, count);
        end
    endtask

    task automatic test_underflow();
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        tick();
        tests++;
        if (underflow !== 1'b1 || count !== 3'd0 || rdata !== 8'h04 || rempty !== 1'b1) begin
            fails++;
            $display("FAIL underflow: got udf=%b cnt=%0d rd=%h e=%b expected udf=1 cnt=0 rd=04 e=1",
                     underflow, count, rdata, rempty);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_rd;
        winc  = 1'b1;
        wdata = 8'hA0;
        tick();
        wdata = 8'hA1;
        tick();
        tests++;
        if (count !== 3'd2) begin
            fails++;
            $display("FAIL b2b_prefill: got cnt=%0d expected 2", count);
        end
        rinc = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wdata = 8'hB0 + 8'(k);
            tick();
            exp_rd = (k == 0) ? 8'hA0 : (k == 1) ? 8'hA1 : 8'hB0 + 8'(k - 2);
            tests++;
            if (count !== 3'd2 || rdata !== exp_rd) begin
                fails++;
                $display("FAIL b2b_%0d: got cnt=%0d rd=%h expected cnt=2 rd=%h",
                         k, count, rdata, exp_rd);
            end
        end
        winc = 1'b0;
        for (int k = 8; k < 10; k++) begin
            tick();
            tests++;
            if (rdata !== 8'hB0 + 8'(k)) begin
                fails++;
                $display("FAIL b2b_tail_%0d: got %h expected %h", k, rdata, 8'hB0 + 8'(k));
            end
        end
        rinc = 1'b0;
        tick();
        tests++;
        if (count !== 3'd0 || rempty !== 1'b1) begin
            fails++;
            $display("FAIL b2b_end: got cnt=%0d e=%b expected cnt=0 e=1", count, rempty);
        end
    endtask

    task automatic test_reset_mid();
        winc = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wdata = 8'hC0 + 8'(i);
            tick();
        end
        winc = 1'b0;
        tests++;
        if (count !== 3'd3 || overflow !== 1'b1 || underflow !== 1'b1) begin
            fails++;
            $display("FAIL rstmid_pre: got cnt=%0d ovf=%b udf=%b expected cnt=3 ovf=1 udf=1",
                     count, overflow, underflow);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (count !== 3'd0 || rempty !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0 ||
            walmost_full !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_clear: got cnt=%0d e=%b ovf=%b udf=%b af=%b expected cnt=0 e=1 ovf=0 udf=0 af=0",
                     count, rempty, overflow, underflow, walmost_full);
        end
        winc  = 1'b1;
        wdata = 8'hD0;
        tick();
        winc = 1'b0;
        rinc = 1'b1;
        tick();
        rinc = 1'b0;
        tests++;
        if (rdata !== 8'hD0 || count !== 3'd0) begin
            fails++;
            $display("FAIL rstmid_new: got rd=%h cnt=%0d expected rd=d0 cnt=0", rdata, count);
        end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
